instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Upstream stage of instruction_decoder. Owns the program counter and fetches each
//   32-bit instruction as four little-endian bytes over the 8-bit memory port.
//   Presents a stable instruction/PC pair with a valid/accept handshake.
//   Takes the next PC from redirect_address (taken branch/jump) or PC+4.
// PARAMETERS
//   RESET_ADDRESS  32'h0000_0000  PC value loaded on reset; must be 4-byte aligned
// PORTS
//   clock             in   1   system clock, rising edge
//   reset             in   1   asynchronous, active-high reset
//   memory_request    out  1   byte fetch requested at memory_address
//   memory_address    out  32  byte address = program_counter + byte_index
//   memory_ready      in   1   memory_data is valid this cycle (one byte transferred)
//   memory_data       in   8   fetched byte
//   instruction       out  32  assembled instruction, to decoder
//   instruction_valid out  1   instruction/program_counter hold a complete fetch
//   instruction_accept in  1   core consumes instruction this cycle
//   redirect          in   1   taken branch/jump for the accepted instruction
//   redirect_address  in  32   target PC when redirect=1
//   program_counter   out 32   address of the held or in-flight instruction
//   fetch_error       out  1   misaligned redirect detected (see CONFIGURATION)
// BEHAVIOUR
//   - State machine: START -> FETCH -> HOLD -> FETCH ... ; ERROR is terminal (macro only).
//   - Reset (async, any state, mid-fetch included): state=START, program_counter=RESET_ADDRESS,
//     byte_index=0, instruction=0, instruction_valid=0, memory_request=0, fetch_error=0.
//     Partially assembled bytes are discarded.
//   - START: one cycle, no request; then goes to FETCH.
//   - FETCH: memory_request=1. Each cycle with memory_ready=1, memory_data is written to
//     instruction[8*byte_index +: 8] and byte_index increments.
//     On the 4th byte: byte_index->0, state->HOLD, instruction_valid=1 on the next cycle.
//     Wait states are unbounded; memory_ready with memory_request=0 is ignored.
//   - Latency: 1 + N cycles from reset release to instruction_valid (N = cycles to collect 4 bytes).
//     Minimum is 5 cycles; minimum is 4 cycles per instruction after that.
//   - HOLD: memory_request=0. instruction and program_counter are stable while
//     instruction_valid=1 and accept=0.
//     On instruction_accept=1: instruction_valid->0, state->FETCH, and program_counter becomes
//     redirect ? redirect_address : program_counter+4, registered on the same edge.
//   - redirect is sampled only when HOLD and instruction_accept are both true; otherwise it is ignored.
//   - Arithmetic: PC+4 and PC+byte_index are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0.
//   - instruction_accept outside HOLD has no effect.
// CONFIGURATION
//   FETCH_ALIGNMENT_CHECK_EN defined:
//     - An accepted redirect with redirect_address[1:0]!=0 sets fetch_error=1 and enters ERROR.
//     - ERROR: memory_request=0, instruction_valid=0, program_counter=redirect_address.
//       Only reset leaves ERROR.
//   FETCH_ALIGNMENT_CHECK_EN undefined:
//     - redirect_address[1:0] is forced to 2'b00. fetch_error is tied to 0. There is no ERROR state.
// TESTING
//   1. Reset; memory returns bytes 93,00,50,00 with ready=1 every cycle ->
//      memory_address 0,1,2,3; instruction=32'h0050_0093 valid at cycle 5; program_counter=0.
//   2. Hold accept=0 for 10 cycles -> instruction, program_counter, valid stable; memory_request=0.
//      Then accept=1, redirect=0 -> next fetch starts at memory_address 32'h4.
//   3. Accept with redirect=1, redirect_address=32'h100 -> program_counter=32'h100;
//      next fetch addresses are 100..103.
//   4. Ready toggles 1,0,0,1,0,1,1 -> exactly 4 bytes captured in order; valid only after the 4th.
//   5. Assert reset after 2 bytes of a fetch -> all outputs return to reset values;
//      the next fetch restarts at RESET_ADDRESS byte 0.
//   6. PC=32'hFFFF_FFFC, accept with no redirect -> next program_counter=0.
//      With macro: redirect_address=32'h102 -> fetch_error=1, memory_request stays 0.
//      Without macro: the same redirect fetches from 32'h100.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose
//   Front end of the instruction pipeline, feeding instruction_decoder. It owns
//   the program counter. It fetches each 32-bit instruction as four
//   little-endian bytes over an 8-bit memory port. It then holds the assembled
//   instruction together with its PC until the core accepts it. The next PC is
//   either the redirect target (taken branch/jump) or PC+4.
//
// Configuration
//   FETCH_ALIGNMENT_CHECK_EN (macro)
//     defined   : an accepted redirect to a non word-aligned target raises
//                 fetch_error_o and parks the unit in a terminal ERROR state
//                 (only reset leaves it).
//     undefined : the two low bits of the redirect target are forced to zero,
//                 fetch_error_o is tied low and there is no ERROR state.
//
// Parameters
//   RESET_ADDRESS        PC loaded on reset; must be 4-byte aligned.
//
// Ports
//   clock_i              system clock, rising edge
//   reset_i              asynchronous, active-high reset
//   memory_request_o     a byte fetch is requested at memory_address_o
//   memory_address_o     byte address = program_counter + byte index
//   memory_ready_i       memory_data_i carries a valid byte this cycle
//   memory_data_i        fetched byte
//   instruction_o        assembled instruction for the decoder
//   instruction_valid_o  instruction_o / program_counter_o hold a full fetch
//   instruction_accept_i core consumes the held instruction this cycle
//   redirect_i           taken branch/jump for the accepted instruction
//   redirect_address_i   target PC when redirect_i is set
//   program_counter_o    address of the held or in-flight instruction
//   fetch_error_o        misaligned redirect detected (macro build only)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic        memory_request_o,
  output logic [31:0] memory_address_o,
  input  logic        memory_ready_i,
  input  logic [7:0]  memory_data_i,
  output logic [31:0] instruction_o,
  output logic        instruction_valid_o,
  input  logic        instruction_accept_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_address_i,
  output logic [31:0] program_counter_o,
  output logic        fetch_error_o
);

`ifdef FETCH_ALIGNMENT_CHECK_EN
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] redirect_target;

`ifdef FETCH_ALIGNMENT_CHECK_EN
  logic        error_q, error_d;

  // The full target is kept so that a misaligned address is both detected and
  // reported on program_counter_o while in ERROR.
  assign redirect_target = redirect_address_i;
  assign fetch_error_o   = error_q;
`else
  // Without the check, the low bits are simply dropped so the PC always stays
  // word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_address_i[1:0];
  assign redirect_target      = {redirect_address_i[31:2], 2'b00};
  assign fetch_error_o        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_START;
      pc_q       <= RESET_ADDRESS;
      byte_idx_q <= 2'd0;
      instr_q    <= 32'h0000_0000;
      valid_q    <= 1'b0;
`ifdef FETCH_ALIGNMENT_CHECK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
`ifdef FETCH_ALIGNMENT_CHECK_EN
      error_q    <= error_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    byte_idx_d       = byte_idx_q;
    instr_d          = instr_q;
    valid_d          = valid_q;
    memory_request_o = 1'b0;
`ifdef FETCH_ALIGNMENT_CHECK_EN
    error_d          = error_q;
`endif

    case (state_q)
      // One idle cycle after reset before the first request goes out.
      ST_START: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        memory_request_o = 1'b1;
        if (memory_ready_i) begin
          // Little-endian assembly: byte k lands in bits [8k+7:8k].
          instr_d[{byte_idx_q, 3'b000} +: 8] = memory_data_i;
          // The 2-bit index wraps back to 0 after the fourth byte.
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // redirect_i only matters on the accepting cycle.
        if (instruction_accept_i) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
          if (redirect_i) begin
            pc_d = redirect_target;
`ifdef FETCH_ALIGNMENT_CHECK_EN
            if (redirect_target[1:0] != 2'b00) begin
              state_d = ST_ERROR;
              error_d = 1'b1;
            end
`endif
          end else begin
            pc_d = pc_q + 32'd4;  // wraps modulo 2^32
          end
        end
      end

`ifdef FETCH_ALIGNMENT_CHECK_EN
      // Terminal: no requests, nothing valid, until reset.
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
`endif

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign memory_address_o    = pc_q + {30'd0, byte_idx_q};
  assign instruction_o       = instr_q;
  assign instruction_valid_o = valid_q;
  assign program_counter_o   = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. Inputs change 1 time unit after
// the rising edge and outputs are checked at that point too, well away from
// the next edge. Defining FETCH_ALIGNMENT_CHECK_EN selects the expectations
// for the misaligned-redirect case.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memory_request;
  logic [31:0] memory_address;
  logic        memory_ready = 1'b0;
  logic [7:0]  memory_data = 8'h00;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        instruction_accept = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_address = 32'h0;
  logic [31:0] program_counter;
  logic        fetch_error;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(
    .RESET_ADDRESS(32'h0000_0000)
  ) dut (
    .clock_i             (clock),
    .reset_i             (reset),
    .memory_request_o    (memory_request),
    .memory_address_o    (memory_address),
    .memory_ready_i      (memory_ready),
    .memory_data_i       (memory_data),
    .instruction_o       (instruction),
    .instruction_valid_o (instruction_valid),
    .instruction_accept_i(instruction_accept),
    .redirect_i          (redirect),
    .redirect_address_i  (redirect_address),
    .program_counter_o   (program_counter),
    .fetch_error_o       (fetch_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, observed);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'd0, memory_request},    32'd0);
    check_eq({tag, "_valid"}, {31'd0, instruction_valid}, 32'd0);
    check_eq({tag, "_pc"},    program_counter,            32'h0);
    check_eq({tag, "_instr"}, instruction,                32'h0);
    check_eq({tag, "_err"},   {31'd0, fetch_error},       32'd0);
  endtask

  // Serves one instruction fetch. pat[c] gives memory_ready for cycle c
  // (ready=1 beyond pat_len). With poke set, stall cycles also drive a
  // spurious accept+redirect, which a fetching unit must ignore.
  task automatic fetch_word(input string tag, input logic [31:0] base,
                            input logic [31:0] word, input logic [15:0] pat,
                            input int pat_len, input bit poke,
                            output int cycles);
    int  idx;
    bit  rdy;
    logic [31:0] w;
    idx    = 0;
    cycles = 0;
    w      = word;
    while (idx < 4 && cycles < 32) begin
      rdy = (cycles < pat_len) ? pat[cycles] : 1'b1;
      check_eq({tag, "_valid_early"}, {31'd0, instruction_valid}, 32'd0);
      if (rdy) begin
        check_eq({tag, "_req"},  {31'd0, memory_request}, 32'd1);
        check_eq({tag, "_addr"}, memory_address, base + idx);
        memory_ready       = 1'b1;
        memory_data        = w[8*idx +: 8];
        instruction_accept = 1'b0;
        redirect           = 1'b0;
        idx++;
      end else begin
        memory_ready = 1'b0;
        memory_data  = 8'hEE;
        if (poke) begin
          instruction_accept = 1'b1;
          redirect           = 1'b1;
          redirect_address   = 32'hDEAD_0000;
        end
      end
      next_cycle();
      cycles++;
    end
    memory_ready       = 1'b0;
    instruction_accept = 1'b0;
    redirect           = 1'b0;
    redirect_address   = 32'h0;
    if (idx < 4) check_eq({tag, "_timeout_bytes"}, idx, 32'd4);
    check_eq({tag, "_valid"}, {31'd0, instruction_valid}, 32'd1);
    check_eq({tag, "_instr"}, instruction, word);
    check_eq({tag, "_pc"},    program_counter, base);
    check_eq({tag, "_req_hold"}, {31'd0, memory_request}, 32'd0);
  endtask

  task automatic do_accept(input string tag, input bit redir,
                           input logic [31:0] addr, input logic [31:0] exp_pc);
    check_eq({tag, "_pre_valid"}, {31'd0, instruction_valid}, 32'd1);
    instruction_accept = 1'b1;
    redirect           = redir;
    redirect_address   = addr;
    next_cycle();
    instruction_accept = 1'b0;
    redirect           = 1'b0;
    redirect_address   = 32'h0;
    check_eq({tag, "_valid"}, {31'd0, instruction_valid}, 32'd0);
    check_eq({tag, "_pc"},    program_counter, exp_pc);
  endtask

  initial begin
    int cyc;
    logic [31:0] held_instr;

    // ---- Reset values -------------------------------------------------------
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    // START cycle: no request yet
    check_eq("start_req", {31'd0, memory_request}, 32'd0);
    next_cycle();

    // ---- 1: first fetch at 0, ready every cycle, valid after 1+4 cycles -----
    fetch_word("t1", 32'h0, 32'h0050_0093, 16'hFFFF, 0, 1'b0, cyc);
    check_eq("t1_latency", 32'(cyc + 1), 32'd5);

    // ---- 2: hold with accept low; ready/redirect noise is ignored -----------
    held_instr = 32'h0050_0093;
    for (int i = 0; i < 10; i++) begin
      memory_ready     = 1'b1;
      memory_data      = 8'hFF;
      redirect         = 1'b1;
      redirect_address = 32'h0000_0800;
      next_cycle();
      check_eq("t2_hold_valid", {31'd0, instruction_valid}, 32'd1);
      check_eq("t2_hold_instr", instruction, held_instr);
      check_eq("t2_hold_pc",    program_counter, 32'h0);
      check_eq("t2_hold_req",   {31'd0, memory_request}, 32'd0);
    end
    memory_ready     = 1'b0;
    redirect         = 1'b0;
    redirect_address = 32'h0;
    do_accept("t2_acc", 1'b0, 32'h0, 32'h4);
    fetch_word("t2", 32'h4, 32'h1234_5678, 16'hFFFF, 0, 1'b0, cyc);
    check_eq("t2_cycles", cyc, 32'd4);

    // ---- 3+4: redirect to 0x100, ready pattern 1,0,0,1,0,1,1 ----------------
    do_accept("t3_acc", 1'b1, 32'h0000_0100, 32'h100);
    fetch_word("t4", 32'h100, 32'hA5C3_0F81, 16'h0069, 7, 1'b1, cyc);
    check_eq("t4_cycles", cyc, 32'd7);

    // ---- 5: reset after two bytes of a fetch --------------------------------
    do_accept("t5_acc", 1'b0, 32'h0, 32'h104);
    for (int i = 0; i < 2; i++) begin
      check_eq("t5_addr", memory_address, 32'h104 + i);
      memory_ready = 1'b1;
      memory_data  = 8'h11 * (i + 1);
      next_cycle();
    end
    memory_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    next_cycle();
    reset = 1'b0;
    check_eq("t5_start_req", {31'd0, memory_request}, 32'd0);
    next_cycle();
    fetch_word("t5", 32'h0, 32'hCAFE_BABE, 16'hFFFF, 0, 1'b0, cyc);

    // ---- 6: PC wrap and misaligned redirect ---------------------------------
    do_accept("t6_acc_hi", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch_word("t6_hi", 32'hFFFF_FFFC, 32'h0000_0013, 16'hFFFF, 0, 1'b0, cyc);
    do_accept("t6_acc_wrap", 1'b0, 32'h0, 32'h0);
    fetch_word("t6_wrap", 32'h0, 32'h0102_0304, 16'hFFFF, 0, 1'b0, cyc);
`ifdef FETCH_ALIGNMENT_CHECK_EN
    do_accept("t6_acc_mis", 1'b1, 32'h0000_0102, 32'h102);
    for (int i = 0; i < 3; i++) begin
      check_eq("t6_err",       {31'd0, fetch_error},       32'd1);
      check_eq("t6_err_req",   {31'd0, memory_request},    32'd0);
      check_eq("t6_err_valid", {31'd0, instruction_valid}, 32'd0);
      check_eq("t6_err_pc",    program_counter,            32'h102);
      memory_ready       = 1'b1;
      instruction_accept = 1'b1;
      next_cycle();
    end
    memory_ready       = 1'b0;
    instruction_accept = 1'b0;
`else
    do_accept("t6_acc_mis", 1'b1, 32'h0000_0102, 32'h100);
    check_eq("t6_noerr", {31'd0, fetch_error}, 32'd0);
    fetch_word("t6_mis", 32'h100, 32'h00A0_0B0C, 16'hFFFF, 0, 1'b0, cyc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
